// File: rtl/xbar_switch_allocator.sv
// xbar_switch_allocator: wormhole switch allocator for a 5-port (N,S,W,E,L) crossbar, one lock per output.
// Latency: one allocation cycle, then flits are granted combinationally while locked; one idle bubble between packets.
// Backpressure: gnt_o follows out_ready_i of the locked output and the lock is held through stalls;
//   XBAR_ALLOC_TIMEOUT_EN adds a per-output watchdog that force-releases a lock stuck without grants.
module xbar_switch_allocator #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  req_i,
  input  logic [14:0] dest_i,
  input  logic [4:0]  tail_i,
  input  logic [4:0]  out_ready_i,
  output logic [4:0]  gnt_o,
  output logic [14:0] demux_sel_o,
  output logic [14:0] mux_sel_o,
  output logic [4:0]  enable_o,
  output logic [4:0]  bad_dest_o,
  output logic [4:0]  timeout_o
);
  localparam int NP = 5;

  if (TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("xbar_switch_allocator: TIMEOUT_CYC must be at least 1");
  end

  // Per-output lock state, owning input and round-robin pointer.
  logic [NP-1:0]        lock_q, lock_d;
  logic [NP-1:0][2:0]   owner_q, owner_d;
  logic [NP-1:0][2:0]   rr_q, rr_d;

  // Input-side view of the locks, arbitration results and forced releases.
  logic [NP-1:0]        in_lock;
  logic [NP-1:0][2:0]   in_out;
  logic [NP-1:0][NP-1:0] vreq;
  logic [NP-1:0]        win_vld;
  logic [NP-1:0][2:0]   win;
  logic [NP-1:0]        tmo_fire;

  // Map each locked output back onto its owning input.
  always_comb begin
    in_lock = '0;
    in_out  = '0;
    for (int p = 0; p < NP; p++) begin
      for (int q = 0; q < NP; q++) begin
        if (lock_q[q] && owner_q[q] == 3'(p)) begin
          in_lock[p] = 1'b1;
          in_out[p]  = 3'(q);
        end
      end
    end
  end

  // Crossbar steering, grants and destination sanity flags.
  always_comb begin
    gnt_o       = '0;
    demux_sel_o = '0;
    mux_sel_o   = '0;
    enable_o    = '0;
    bad_dest_o  = '0;
    for (int p = 0; p < NP; p++) begin
      enable_o[p]   = in_lock[p];
      bad_dest_o[p] = req_i[p] & ((dest_i[3*p +: 3] > 3'd4) | (dest_i[3*p +: 3] == 3'(p)));
      if (in_lock[p]) begin
        demux_sel_o[3*p +: 3] = in_out[p];
        gnt_o[p]              = req_i[p] & out_ready_i[in_out[p]];
      end
    end
    for (int q = 0; q < NP; q++) begin
      if (lock_q[q]) mux_sel_o[3*q +: 3] = owner_q[q];
    end
  end

  // Round-robin pick per output among unlocked, legal requesters, starting at rr_q.
  always_comb begin
    vreq    = '0;
    win_vld = '0;
    win     = '0;
    for (int q = 0; q < NP; q++) begin
      for (int p = 0; p < NP; p++) begin
        vreq[q][p] = req_i[p] & ~in_lock[p] & (dest_i[3*p +: 3] == 3'(q)) & (p != q);
      end
      for (int k = 0; k < NP; k++) begin
        if (!win_vld[q] && vreq[q][(int'(rr_q[q]) + k) % NP]) begin
          win_vld[q] = 1'b1;
          win[q]     = 3'((int'(rr_q[q]) + k) % NP);
        end
      end
    end
  end

  // Lock on a winner, release after a granted tail flit or a watchdog expiry.
  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    for (int q = 0; q < NP; q++) begin
      if (!lock_q[q]) begin
        if (win_vld[q]) begin
          lock_d[q]  = 1'b1;
          owner_d[q] = win[q];
          rr_d[q]    = (win[q] == 3'd4) ? 3'd0 : win[q] + 3'd1;
        end
      end else if ((gnt_o[owner_q[q]] & tail_i[owner_q[q]]) | tmo_fire[q]) begin
        lock_d[q] = 1'b0;
      end
    end
  end

  // Allocation state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q  <= '0;
      owner_q <= '0;
      rr_q    <= '0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

`ifdef XBAR_ALLOC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [NP-1:0][CW-1:0] cnt_q, cnt_d;

  // Count locked cycles without a grant; fire once the count reaches TIMEOUT_CYC.
  always_comb begin
    tmo_fire = '0;
    cnt_d    = '0;
    for (int q = 0; q < NP; q++) begin
      tmo_fire[q] = lock_q[q] && (cnt_q[q] == CW'(TIMEOUT_CYC));
      if (lock_q[q] && !gnt_o[owner_q[q]] && !tmo_fire[q]) cnt_d[q] = cnt_q[q] + CW'(1);
    end
  end

  // Watchdog counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign timeout_o = tmo_fire;
`else
  assign tmo_fire  = '0;
  assign timeout_o = '0;
`endif

endmodule

// File: tb/tb_xbar_switch_allocator.sv
`timescale 1ns/1ps
module tb_xbar_switch_allocator;
  logic        clk = 1'b0;
  logic        rst_ni;
  logic [4:0]  req, tail, ready;
  logic [14:0] dest;
  logic [4:0]  gnt, enable, bad_dest, tmo;
  logic [14:0] demux_sel, mux_sel;
  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  xbar_switch_allocator #(.TIMEOUT_CYC(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .dest_i(dest), .tail_i(tail),
    .out_ready_i(ready), .gnt_o(gnt), .demux_sel_o(demux_sel), .mux_sel_o(mux_sel),
    .enable_o(enable), .bad_dest_o(bad_dest), .timeout_o(tmo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] dst(input logic [2:0] n, s, w, e, l);
    return {l, e, w, s, n};
  endfunction

  // Contention on L: N, S, W, two flits each.
  logic [4:0] t2_req  [10] = '{5'b00111, 5'b00111, 5'b00111, 5'b00110, 5'b00110,
                               5'b00110, 5'b00100, 5'b00100, 5'b00100, 5'b00000};
  logic [4:0] t2_tail [10] = '{5'b00000, 5'b00000, 5'b00001, 5'b00000, 5'b00000,
                               5'b00010, 5'b00000, 5'b00000, 5'b00100, 5'b00000};
  logic [4:0] t2_gnt  [10] = '{5'b00000, 5'b00001, 5'b00001, 5'b00000, 5'b00010,
                               5'b00010, 5'b00000, 5'b00100, 5'b00100, 5'b00000};
  logic [2:0] t2_mux  [10] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd2, 3'd2, 3'd0};

  // Backpressure: W->N three flits, N stalled four cycles.
  logic [4:0] t3_req  [9] = '{5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100,
                              5'b00100, 5'b00100, 5'b00100, 5'b00000};
  logic [4:0] t3_rdy  [9] = '{5'h1f, 5'h1f, 5'h1e, 5'h1e, 5'h1e, 5'h1e, 5'h1f, 5'h1f, 5'h1f};
  logic [4:0] t3_tail [9] = '{5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b00100, 5'b0};
  logic [4:0] t3_gnt  [9] = '{5'b0, 5'b00100, 5'b0, 5'b0, 5'b0, 5'b0, 5'b00100, 5'b00100, 5'b0};
  logic [4:0] t3_en   [9] = '{5'b0, 5'b00100, 5'b00100, 5'b00100, 5'b00100,
                              5'b00100, 5'b00100, 5'b00100, 5'b0};
  logic [2:0] t3_mux  [9] = '{3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0; req = '0; dest = '0; tail = '0; ready = 5'h1f;
    #3;
    check("rst_gnt", 32'(gnt), 'h0);
    check("rst_en", 32'(enable), 'h0);
    check("rst_mux", 32'(mux_sel), 'h0);
    check("rst_demux", 32'(demux_sel), 'h0);
    check("rst_tmo", 32'(tmo), 'h0);
    @(negedge clk);
    rst_ni = 1'b1;

    // Single flit L->E.
    tick(); req = 5'b10000; dest = dst(0, 0, 0, 0, 3); tail = 5'b10000; #1;
    check("sf_alloc_gnt", 32'(gnt), 'h0);
    check("sf_alloc_en", 32'(enable), 'h0);
    tick(); #1;
    check("sf_gnt", 32'(gnt), 'b10000);
    check("sf_demux_L", 32'(demux_sel[14:12]), 'd3);
    check("sf_mux_E", 32'(mux_sel[11:9]), 'd4);
    check("sf_en", 32'(enable), 'b10000);
    tick(); req = '0; tail = '0; #1;
    check("sf_idle_en", 32'(enable), 'h0);
    check("sf_idle_mux", 32'(mux_sel), 'h0);

    // Contention N, S, W -> L.
    dest = dst(4, 4, 4, 0, 0);
    for (int c = 0; c < 10; c++) begin
      tick(); req = t2_req[c]; tail = t2_tail[c]; #1;
      check($sformatf("ct_gnt_c%0d", c), 32'(gnt), 32'(t2_gnt[c]));
      check($sformatf("ct_en_c%0d", c), 32'(enable), 32'(t2_gnt[c]));
      check($sformatf("ct_muxL_c%0d", c), 32'(mux_sel[14:12]), 32'(t2_mux[c]));
    end

    // Backpressure W->N; W's dest changes while locked and must be ignored.
    dest = dst(0, 0, 0, 0, 0);
    for (int c = 0; c < 9; c++) begin
      tick(); req = t3_req[c]; ready = t3_rdy[c]; tail = t3_tail[c];
      if (c == 2) dest = dst(0, 0, 3, 0, 0);
      #1;
      check($sformatf("bp_gnt_c%0d", c), 32'(gnt), 32'(t3_gnt[c]));
      check($sformatf("bp_en_c%0d", c), 32'(enable), 32'(t3_en[c]));
      check($sformatf("bp_muxN_c%0d", c), 32'(mux_sel[2:0]), 32'(t3_mux[c]));
      if (c >= 1 && c <= 7) check($sformatf("bp_demuxW_c%0d", c), 32'(demux_sel[8:6]), 'd0);
    end
    ready = 5'h1f; tail = '0;

    // Illegal: U-turn then invalid code.
    tick(); req = 5'b00010; dest = dst(0, 1, 0, 0, 0); #1;
    check("il_uturn_bad", 32'(bad_dest), 'b00010);
    check("il_uturn_gnt", 32'(gnt), 'h0);
    tick(); #1;
    check("il_uturn_en", 32'(enable), 'h0);
    tick(); dest = dst(0, 6, 0, 0, 0); #1;
    check("il_code6_bad", 32'(bad_dest), 'b00010);
    tick(); #1;
    check("il_code6_en", 32'(enable), 'h0);
    check("il_code6_mux", 32'(mux_sel), 'h0);
    tick(); req = '0; #1;
    check("il_clear_bad", 32'(bad_dest), 'h0);

    // Round robin on L continues from pointer 3: E beats N.
    tick(); req = 5'b01001; dest = dst(4, 0, 0, 4, 0); tail = 5'b01001; #1;
    check("rr_alloc_gnt", 32'(gnt), 'h0);
    tick(); #1;
    check("rr_first_gnt", 32'(gnt), 'b01000);
    check("rr_first_mux", 32'(mux_sel[14:12]), 'd3);
    tick(); req = 5'b00001; #1;
    check("rr_bubble_en", 32'(enable), 'h0);
    tick(); #1;
    check("rr_second_gnt", 32'(gnt), 'b00001);
    tick(); req = '0; tail = '0; #1;
    check("rr_idle_en", 32'(enable), 'h0);

    // Independent allocation: N->E and S->W at once.
    tick(); req = 5'b00011; dest = dst(3, 2, 0, 0, 0); tail = 5'b00011; #1;
    check("ind_alloc_gnt", 32'(gnt), 'h0);
    tick(); #1;
    check("ind_gnt", 32'(gnt), 'b00011);
    check("ind_mux_E", 32'(mux_sel[11:9]), 'd0);
    check("ind_mux_W", 32'(mux_sel[8:6]), 'd1);
    check("ind_demux_N", 32'(demux_sel[2:0]), 'd3);
    check("ind_demux_S", 32'(demux_sel[5:3]), 'd2);
    tick(); req = '0; tail = '0; #1;
    check("ind_idle_en", 32'(enable), 'h0);

    // E->S locked, then E drops its request without a tail.
    tick(); req = 5'b01000; dest = dst(0, 0, 0, 1, 0); #1;
    check("to_alloc_gnt", 32'(gnt), 'h0);
    tick(); req = '0; #1;
`ifdef XBAR_ALLOC_TIMEOUT_EN
    for (int i = 1; i <= 10; i++) begin
      if (i <= 8) begin
        check($sformatf("to_hold_en_%0d", i), 32'(enable), 'b01000);
        check($sformatf("to_hold_tmo_%0d", i), 32'(tmo), 'h0);
      end else if (i == 9) begin
        check("to_pulse_tmo", 32'(tmo), 'b00010);
        check("to_pulse_en", 32'(enable), 'b01000);
      end else begin
        check("to_release_en", 32'(enable), 'h0);
        check("to_release_tmo", 32'(tmo), 'h0);
      end
      tick(); #1;
    end
`else
    for (int i = 1; i <= 12; i++) begin
      check($sformatf("to_hold_en_%0d", i), 32'(enable), 'b01000);
      check($sformatf("to_hold_tmo_%0d", i), 32'(tmo), 'h0);
      check($sformatf("to_hold_mux_%0d", i), 32'(mux_sel[5:3]), 'd3);
      tick(); #1;
    end
    req = 5'b01000; tail = 5'b01000; #1;
    check("to_tail_gnt", 32'(gnt), 'b01000);
    tick(); req = '0; tail = '0; #1;
    check("to_tail_en", 32'(enable), 'h0);
`endif

    // Reset mid-packet S->W, then a fresh contention on L starts from pointer 0.
    tick(); req = 5'b00010; dest = dst(0, 2, 0, 0, 0); tail = '0; #1;
    tick(); #1;
    check("mr_pre_gnt", 32'(gnt), 'b00010);
    #2; rst_ni = 1'b0; #1;
    check("mr_gnt", 32'(gnt), 'h0);
    check("mr_en", 32'(enable), 'h0);
    check("mr_mux", 32'(mux_sel), 'h0);
    check("mr_demux", 32'(demux_sel), 'h0);
    check("mr_tmo", 32'(tmo), 'h0);
    req = '0;
    @(negedge clk);
    rst_ni = 1'b1;
    tick(); req = 5'b00011; dest = dst(4, 4, 0, 0, 0); tail = 5'b00011; #1;
    check("mr_alloc_gnt", 32'(gnt), 'h0);
    tick(); #1;
    check("mr_rr0_gnt", 32'(gnt), 'b00001);
    check("mr_rr0_en", 32'(enable), 'b00001);
    tick(); req = 5'b00010; #1;
    check("mr_bubble_en", 32'(enable), 'h0);
    tick(); #1;
    check("mr_second_gnt", 32'(gnt), 'b00010);
    check("mr_second_mux", 32'(mux_sel[14:12]), 'd1);
    tick(); req = '0; tail = '0; #1;
    check("mr_idle_en", 32'(enable), 'h0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
